// File: rtl/core_pkg.sv
// Shared types and constants for the core sequencer.
// Build option: CORE_SEQ_PERF_EN enables the cycle/instret counters.
package core_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } seq_state_t;

    localparam logic [6:0]  OPCODE_OPIMM = 7'b0010011;
    localparam logic [2:0]  FUNCT3_ADDI  = 3'b000;
    localparam int unsigned INSTR_BYTES  = 4;

    // ADDI is the only instruction the core currently executes.
    function automatic logic is_addi(input logic [31:0] instr);
        return (instr[6:0] == OPCODE_OPIMM) && (instr[14:12] == FUNCT3_ADDI);
    endfunction

endpackage

// File: rtl/core_perf_counters.sv
// Free-running performance counters: active cycles and retired instructions.
// Only instantiated when CORE_SEQ_PERF_EN is defined.
module core_perf_counters (
    input  logic        i_clock,
    input  logic        i_resetn,
    input  logic        active,
    input  logic        retire,
    output logic [31:0] cycle_count,
    output logic [31:0] instret
);

    // Both counters wrap naturally at 2^32.
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            cycle_count <= '0;
            instret     <= '0;
        end else begin
            if (active) cycle_count <= cycle_count + 32'd1;
            if (retire) instret     <= instret + 32'd1;
        end
    end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the single-issue core.
// Build option: CORE_SEQ_PERF_EN adds cycle and instret counters; otherwise
// o_cycleCount and o_instret read as zero.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for i_start
// FETCH     | o_imemReq high, waiting for i_imemValid (bounded by timer)
// DECODE    | instruction register valid, legality check
// EXECUTE   | ALU operands valid
// WRITEBACK | GPR write strobe (rd != x0), PC advances
// HALT      | sticky stop on illegal instruction or fetch timeout
module core_sequencer
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned IMEM_TIMEOUT = 16
) (
    input  logic        i_clock,
    input  logic        i_resetn,
    input  logic        i_start,
    output logic        o_imemReq,
    output logic [31:0] o_imemAddr,
    input  logic        i_imemValid,
    input  logic [31:0] i_imemData,
    output logic [31:0] o_PC,
    output logic [31:0] o_instr,
    output logic [4:0]  o_rs1Addr,
    output logic [4:0]  o_rdAddr,
    output logic [31:0] o_imm,
    output logic        o_aluEn,
    output logic        o_gprWe,
    output logic        o_halted,
    output logic        o_illegal,
    output logic        o_fetchErr,
    output logic [31:0] o_cycleCount,
    output logic [31:0] o_instret
);

    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};
    localparam int unsigned TMR_W   = (IMEM_TIMEOUT > 1) ? $clog2(IMEM_TIMEOUT) : 1;
    // Timer holds the number of further misses tolerated; zero on a miss means timeout.
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(IMEM_TIMEOUT - 1);

    seq_state_t       state;
    logic [31:0]      pc;
    logic [31:0]      instr;
    logic [TMR_W-1:0] fetch_tmr;
    logic             imem_req;
    logic             alu_en;
    logic             gpr_we;
    logic             halted;
    logic             illegal;
    logic             fetch_err;

    // Sequencer FSM; strobes are registered alongside the state they belong to.
    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            state     <= ST_IDLE;
            pc        <= PC_INIT;
            instr     <= '0;
            fetch_tmr <= '0;
            imem_req  <= 1'b0;
            alu_en    <= 1'b0;
            gpr_we    <= 1'b0;
            halted    <= 1'b0;
            illegal   <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            imem_req <= 1'b0;
            alu_en   <= 1'b0;
            gpr_we   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        pc        <= PC_INIT;
                        fetch_tmr <= TMR_LOAD;
                        imem_req  <= 1'b1;
                        state     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (i_imemValid) begin
                        instr     <= i_imemData;
                        fetch_tmr <= TMR_LOAD;
                        state     <= ST_DECODE;
                    end else if (fetch_tmr == '0) begin
                        halted    <= 1'b1;
                        fetch_err <= 1'b1;
                        state     <= ST_HALT;
                    end else begin
                        fetch_tmr <= fetch_tmr - 1'b1;
                        imem_req  <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (is_addi(instr)) begin
                        alu_en <= 1'b1;
                        state  <= ST_EXECUTE;
                    end else begin
                        // PC is left pointing at the faulting instruction.
                        halted  <= 1'b1;
                        illegal <= 1'b1;
                        state   <= ST_HALT;
                    end
                end
                ST_EXECUTE: begin
                    gpr_we <= (instr[11:7] != 5'd0);
                    state  <= ST_WRITEBACK;
                end
                ST_WRITEBACK: begin
                    pc        <= pc + INSTR_BYTES;
                    fetch_tmr <= TMR_LOAD;
                    imem_req  <= 1'b1;
                    state     <= ST_FETCH;
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Instruction fields come from the instruction register, stable DECODE..WRITEBACK.
    always_comb begin
        o_rs1Addr = instr[19:15];
        o_rdAddr  = instr[11:7];
        o_imm     = {{20{instr[31]}}, instr[31:20]};
    end

    assign o_imemReq  = imem_req;
    assign o_imemAddr = pc;
    assign o_PC       = pc;
    assign o_instr    = instr;
    assign o_aluEn    = alu_en;
    assign o_gprWe    = gpr_we;
    assign o_halted   = halted;
    assign o_illegal  = illegal;
    assign o_fetchErr = fetch_err;

`ifdef CORE_SEQ_PERF_EN
    logic perf_active;
    logic perf_retire;

    assign perf_active = (state != ST_IDLE) && (state != ST_HALT);
    assign perf_retire = (state == ST_WRITEBACK);

    core_perf_counters u_perf (
        .i_clock     (i_clock),
        .i_resetn    (i_resetn),
        .active      (perf_active),
        .retire      (perf_retire),
        .cycle_count (o_cycleCount),
        .instret     (o_instret)
    );
`else
    assign o_cycleCount = '0;
    assign o_instret    = '0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: a cycle-by-cycle vector table plus
// hand-written sequences for timeout, address wrap and mid-instruction reset.
module tb_core_sequencer;

    localparam logic [31:0] I_ADDI_X1_5 = 32'h0050_0093;
    localparam logic [31:0] I_ADDI_X0_1 = 32'h0010_0013;
    localparam logic [31:0] I_ADD       = 32'h0000_0033;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_data = '0;

    logic        imem_req, alu_en, gpr_we, halted, illegal, fetch_err;
    logic [31:0] imem_addr, pc, instr, imm, cycle_count, instret;
    logic [4:0]  rs1_addr, rd_addr;

    logic        w_imem_req, w_alu_en, w_gpr_we, w_halted, w_illegal, w_fetch_err;
    logic [31:0] w_imem_addr, w_pc, w_instr, w_imm, w_cycle_count, w_instret;
    logic [4:0]  w_rs1_addr, w_rd_addr;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    core_sequencer #(.RESET_PC(32'h0000_0000), .IMEM_TIMEOUT(16)) dut (
        .i_clock(clock), .i_resetn(resetn), .i_start(start),
        .o_imemReq(imem_req), .o_imemAddr(imem_addr),
        .i_imemValid(imem_valid), .i_imemData(imem_data),
        .o_PC(pc), .o_instr(instr), .o_rs1Addr(rs1_addr), .o_rdAddr(rd_addr),
        .o_imm(imm), .o_aluEn(alu_en), .o_gprWe(gpr_we), .o_halted(halted),
        .o_illegal(illegal), .o_fetchErr(fetch_err),
        .o_cycleCount(cycle_count), .o_instret(instret)
    );

    core_sequencer #(.RESET_PC(32'hFFFF_FFFC), .IMEM_TIMEOUT(16)) dut_w (
        .i_clock(clock), .i_resetn(resetn), .i_start(start),
        .o_imemReq(w_imem_req), .o_imemAddr(w_imem_addr),
        .i_imemValid(imem_valid), .i_imemData(imem_data),
        .o_PC(w_pc), .o_instr(w_instr), .o_rs1Addr(w_rs1_addr), .o_rdAddr(w_rd_addr),
        .o_imm(w_imm), .o_aluEn(w_alu_en), .o_gprWe(w_gpr_we), .o_halted(w_halted),
        .o_illegal(w_illegal), .o_fetchErr(w_fetch_err),
        .o_cycleCount(w_cycle_count), .o_instret(w_instret)
    );

    typedef struct packed {
        logic        req;
        logic        alu;
        logic        we;
        logic        hlt;
        logic        ill;
        logic        ferr;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rd;
        logic [31:0] imm;
    } obs_t;

    typedef struct {
        logic        start;
        logic        valid;
        logic [31:0] data;
        obs_t        exp;
    } vec_t;

    obs_t act;
    assign act = {imem_req, alu_en, gpr_we, halted, illegal, fetch_err,
                  pc, rs1_addr, rd_addr, imm};

    function automatic obs_t mk(input logic req, alu, we, hlt, ill, ferr,
                                input logic [31:0] p, input logic [4:0] r1, rd,
                                input logic [31:0] im);
        obs_t o;
        o = {req, alu, we, hlt, ill, ferr, p, r1, rd, im};
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got req=%b alu=%b we=%b hlt=%b ill=%b ferr=%b pc=%h rs1=%0d rd=%0d imm=%h, expected req=%b alu=%b we=%b hlt=%b ill=%b ferr=%b pc=%h rs1=%0d rd=%0d imm=%h",
                     name, act.req, act.alu, act.we, act.hlt, act.ill, act.ferr, act.pc, act.rs1, act.rd, act.imm,
                     exp.req, exp.alu, exp.we, exp.hlt, exp.ill, exp.ferr, exp.pc, exp.rs1, exp.rd, exp.imm);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_perf(input string name, input logic [31:0] exp_cyc, input logic [31:0] exp_ret);
`ifdef CORE_SEQ_PERF_EN
        check32({name, "_cycles"}, cycle_count, exp_cyc);
        check32({name, "_instret"}, instret, exp_ret);
`else
        check32({name, "_cycles"}, cycle_count, 32'd0 & exp_cyc);
        check32({name, "_instret"}, instret, 32'd0 & exp_ret);
`endif
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetn = 1'b0;
        start = 1'b0;
        imem_valid = 1'b0;
        imem_data = '0;
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic step(input logic s, input logic v, input logic [31:0] d);
        @(negedge clock);
        start = s;
        imem_valid = v;
        imem_data = d;
        @(posedge clock);
        #1;
    endtask

    vec_t vecs[15];
    obs_t rst_obs;

    initial begin
        rst_obs = mk(0,0,0,0,0,0, 32'h0, 5'd0, 5'd0, 32'h0);

        vecs[0]  = '{1'b1, 1'b0, 32'h0,         mk(1,0,0,0,0,0, 32'h0, 0, 0, 32'h0)};
        vecs[1]  = '{1'b0, 1'b1, I_ADDI_X1_5,   mk(0,0,0,0,0,0, 32'h0, 0, 1, 32'h5)};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,         mk(0,1,0,0,0,0, 32'h0, 0, 1, 32'h5)};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,         mk(0,0,1,0,0,0, 32'h0, 0, 1, 32'h5)};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,         mk(1,0,0,0,0,0, 32'h4, 0, 1, 32'h5)};
        vecs[5]  = '{1'b0, 1'b0, 32'h0,         mk(1,0,0,0,0,0, 32'h4, 0, 1, 32'h5)};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,         mk(1,0,0,0,0,0, 32'h4, 0, 1, 32'h5)};
        vecs[7]  = '{1'b0, 1'b1, I_ADDI_X0_1,   mk(0,0,0,0,0,0, 32'h4, 0, 0, 32'h1)};
        vecs[8]  = '{1'b0, 1'b1, 32'hFFFF_FFFF, mk(0,1,0,0,0,0, 32'h4, 0, 0, 32'h1)};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,         mk(0,0,0,0,0,0, 32'h4, 0, 0, 32'h1)};
        vecs[10] = '{1'b0, 1'b0, 32'h0,         mk(1,0,0,0,0,0, 32'h8, 0, 0, 32'h1)};
        vecs[11] = '{1'b0, 1'b1, I_ADD,         mk(0,0,0,0,0,0, 32'h8, 0, 0, 32'h0)};
        vecs[12] = '{1'b0, 1'b0, 32'h0,         mk(0,0,0,1,1,0, 32'h8, 0, 0, 32'h0)};
        vecs[13] = '{1'b1, 1'b0, 32'h0,         mk(0,0,0,1,1,0, 32'h8, 0, 0, 32'h0)};
        vecs[14] = '{1'b0, 1'b1, I_ADDI_X1_5,   mk(0,0,0,1,1,0, 32'h8, 0, 0, 32'h0)};

        // Reset state.
        do_reset();
        #1;
        check_obs("reset_state", rst_obs);
        check32("reset_pc_wrapdut", w_pc, 32'hFFFF_FFFC);
        check_perf("reset_perf", 32'd0, 32'd0);

        // Table: zero-wait ADDI, 3-cycle wait ADDI to x0, illegal at PC 8, halt stickiness.
        for (int i = 0; i < 15; i++) begin
            step(vecs[i].start, vecs[i].valid, vecs[i].data);
            check_obs($sformatf("vec%0d", i), vecs[i].exp);
            if (i == 4)  check_perf("perf_first_retire", 32'd4, 32'd1);
            if (i == 10) check_perf("perf_second_retire", 32'd10, 32'd2);
            if (i == 14) check_perf("perf_halted_frozen", 32'd12, 32'd2);
        end

        // Fetch timeout: 16 misses halt with fetch error.
        do_reset();
        step(1'b1, 1'b0, 32'h0);
        repeat (15) step(1'b0, 1'b0, 32'h0);
        check_obs("timeout_15_misses", mk(1,0,0,0,0,0, 32'h0, 0, 0, 32'h0));
        step(1'b0, 1'b0, 32'h0);
        check_obs("timeout_halt", mk(0,0,0,1,0,1, 32'h0, 0, 0, 32'h0));
        check_perf("timeout_perf", 32'd16, 32'd0);
        step(1'b1, 1'b1, I_ADDI_X1_5);
        check_obs("timeout_sticky", mk(0,0,0,1,0,1, 32'h0, 0, 0, 32'h0));

        // Valid in the 16th FETCH cycle is still accepted.
        do_reset();
        step(1'b1, 1'b0, 32'h0);
        repeat (15) step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, I_ADDI_X1_5);
        check_obs("timeout_boundary_accept", mk(0,0,0,0,0,0, 32'h0, 0, 1, 32'h5));

        // PC wrap from 0xFFFF_FFFC to 0.
        do_reset();
        step(1'b1, 1'b0, 32'h0);
        check32("wrap_fetch_addr", w_imem_addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b1, I_ADDI_X1_5);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        check32("wrap_gpr_we", {31'd0, w_gpr_we}, 32'd1);
        step(1'b0, 1'b0, 32'h0);
        check32("wrap_pc", w_pc, 32'h0);
        check32("wrap_req", {31'd0, w_imem_req}, 32'd1);

        // Asynchronous reset during EXECUTE.
        do_reset();
        step(1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, I_ADDI_X1_5);
        step(1'b0, 1'b0, 32'h0);
        check_obs("pre_reset_execute", mk(0,1,0,0,0,0, 32'h0, 0, 1, 32'h5));
        #2;
        resetn = 1'b0;
        #1;
        check_obs("async_reset_execute", rst_obs);
        check32("async_reset_wrapdut_pc", w_pc, 32'hFFFF_FFFC);
        @(posedge clock);
        #1;
        check_obs("reset_held_no_we", rst_obs);
        check_perf("reset_perf_clear", 32'd0, 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        step(1'b0, 1'b0, 32'h0);
        check_obs("idle_after_reset", rst_obs);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
# core_sequencer

Multi-cycle control FSM for the single-issue RISC-V core. It owns the PC, issues instruction fetches to IMEM, latches and decodes the instruction (ADDI only at present), and sequences ALU execute and GPR writeback. It sits between IMEM and the decoder/GPR/ALU datapath, and the per-cycle logger samples its outputs.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after i_start; bits [1:0] forced to 0
- IMEM_TIMEOUT, 16, max consecutive FETCH cycles without i_imemValid before fetch error (≥1)

- i_clock  in  1  clock, rising edge
- i_resetn  in  1  reset, asynchronous, active-low
- i_start  in  1  leave IDLE and begin execution; ignored in any other state
- o_imemReq  out  1  fetch request, held high throughout FETCH
- o_imemAddr  out  32  fetch address (= o_PC)
- i_imemValid  in  1  i_imemData valid this cycle; sampled only in FETCH
- i_imemData  in  32  instruction word
- o_PC  out  32  current program counter
- o_instr  out  32  instruction register
- o_rs1Addr  out  5  instr[19:15]
- o_rdAddr  out  5  instr[11:7]
- o_imm  out  32  sign-extended instr[31:20]
- o_aluEn  out  1  ALU operands valid, EXECUTE only
- o_gprWe  out  1  GPR write strobe, WRITEBACK only, suppressed when rd = x0
- o_halted  out  1  FSM in HALT
- o_illegal  out  1  halted on a non-ADDI instruction
- o_fetchErr  out  1  halted on IMEM timeout
- o_cycleCount  out  32  active-cycle counter (see Configuration)
- o_instret  out  32  retired-instruction counter (see Configuration)

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- IDLE: on i_start, PC ← RESET_PC & ~3, go to FETCH.
- FETCH: o_imemReq=1. If i_imemValid, instr ← i_imemData, clear timeout counter, go to DECODE. Otherwise the timeout counter increments. When it would reach IMEM_TIMEOUT, go to HALT with o_fetchErr=1.
- DECODE: legal only if opcode=7'b0010011 and funct3=3'b000. Legal goes to EXECUTE. Otherwise go to HALT with o_illegal=1, and PC stays on the faulting instruction.
- EXECUTE: o_aluEn=1, go to WRITEBACK.
- WRITEBACK: o_gprWe=(rd≠0), PC ← PC+4 modulo 2^32 (0xFFFF_FFFC wraps to 0), go to FETCH.
- HALT: sticky; leaves only on reset. i_start is ignored.
- o_rs1Addr, o_rdAddr and o_imm decode from the instruction register, so they are stable from DECODE through WRITEBACK.

## Timing
- Reset values: state IDLE. PC=RESET_PC&~3. instr=0. Every output 0 except o_PC/o_imemAddr=RESET_PC&~3.
- Zero-wait IMEM (valid in the first FETCH cycle): 4 cycles per instruction, FETCH→DECODE→EXECUTE→WRITEBACK.
- Each wait cycle adds 1. Valid in the IMEM_TIMEOUT-th FETCH cycle is accepted, with no error.
- i_start gives FETCH on the next edge, so first o_imemReq is 1 cycle after i_start is sampled.
- All outputs are registered-state decodes, with no combinational path from inputs to outputs.
- Reset mid-instruction: immediate return to IDLE. No o_gprWe is emitted and counters clear.
- i_imemValid outside FETCH is ignored and any data is dropped.

## Configuration
- CORE_SEQ_PERF_EN defined:
  - o_cycleCount increments every cycle the state is not IDLE or HALT.
  - o_instret increments on each WRITEBACK.
  - Both wrap modulo 2^32 and both clear on reset.
- CORE_SEQ_PERF_EN undefined: both ports remain, tied to 0, with no counter flops.

## Structure
- Package core_pkg:
  - enum seq_state_t
  - OPCODE_OPIMM=7'b0010011, FUNCT3_ADDI=3'b000
  - INSTR_BYTES=4
- Sub-module core_perf_counters: cycle and instret counters, instantiated only under CORE_SEQ_PERF_EN.

## Test plan
- Zero-wait ADDI x1,x0,5 (0x00500093) at PC 0:
  - o_gprWe=1, rdAddr=1 and imm=5 exactly 4 cycles after first o_imemReq.
  - o_PC=4 next.
  - With CORE_SEQ_PERF_EN: instret=1, cycleCount=4.
- Wait states: valid after 3 req cycles → DECODE at cycle 3. Valid withheld 16 cycles (IMEM_TIMEOUT=16) → o_halted=1, o_fetchErr=1, o_imemReq=0.
- Illegal 0x00000033 at PC 8 → o_illegal=1, o_PC=8, no o_gprWe, i_start ignored afterwards.
- ADDI x0,x0,1 → full 4-cycle sequence with o_gprWe=0, PC advances by 4.
- RESET_PC=32'hFFFF_FFFC, legal instruction → o_PC wraps to 0.
- i_resetn low during EXECUTE → outputs at reset values asynchronously, state IDLE, no write strobe.
